// File: rtl/multicycle_main_controller.sv
// Main control FSM for the multicycle RV32I subset core.
// Sequences each instruction through fetch/decode/execute/memory/writeback
// and decodes datapath mux selects, write enables and the ALU operation.
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   op, funct3, funct7       instruction fields from IR
//   zero                     ALU zero flag (combinational, used in BRANCH)
//   pc_write, ir_write, mem_write, reg_write   datapath write enables
//   adr_src, result_src, alu_src_a, alu_src_b, imm_src   datapath selects
//   alu_control              3-bit ALU operation
//   instr_done               last cycle of each instruction
//   illegal                  DECODE pulse for unsupported op/funct
module multicycle_main_controller #(
   parameter bit CHECK_FUNCT7 = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   input  logic       zero,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] imm_src,
   output logic [2:0] alu_control,
   output logic       instr_done,
   output logic       illegal
);

   localparam logic [3:0] S_FETCH     = 4'd0;
   localparam logic [3:0] S_DECODE    = 4'd1;
   localparam logic [3:0] S_MEM_ADR   = 4'd2;
   localparam logic [3:0] S_MEM_READ  = 4'd3;
   localparam logic [3:0] S_MEM_WB    = 4'd4;
   localparam logic [3:0] S_MEM_WRITE = 4'd5;
   localparam logic [3:0] S_EXEC_R    = 4'd6;
   localparam logic [3:0] S_EXEC_I    = 4'd7;
   localparam logic [3:0] S_ALU_WB    = 4'd8;
   localparam logic [3:0] S_BRANCH    = 4'd9;
   localparam logic [3:0] S_JAL       = 4'd10;
   localparam logic [3:0] S_JALR      = 4'd11;
   localparam logic [3:0] S_JALR_PC   = 4'd12;
   localparam logic [3:0] S_LUI       = 4'd13;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [2:0] ALU_ADD   = 3'b000;
   localparam logic [2:0] ALU_SUB   = 3'b001;
   localparam logic [2:0] ALU_AND   = 3'b010;
   localparam logic [2:0] ALU_OR    = 3'b011;
   localparam logic [2:0] ALU_SLT   = 3'b101;
   localparam logic [2:0] ALU_PASSB = 3'b110;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] A_PC    = 2'b00;
   localparam logic [1:0] A_OLDPC = 2'b01;
   localparam logic [1:0] A_RS1   = 2'b10;
   localparam logic [1:0] B_RS2   = 2'b00;
   localparam logic [1:0] B_IMM   = 2'b01;
   localparam logic [1:0] B_FOUR  = 2'b10;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MDR    = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   logic [3:0] state;
   logic [3:0] state_next;
   logic       funct7_bad;

   // Shared funct3 -> ALU op map for register and immediate arithmetic
   function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic is_sub);
      logic [2:0] res;
      case (f3)
         3'b000:  res = is_sub ? ALU_SUB : ALU_ADD;
         3'b010:  res = ALU_SLT;
         3'b110:  res = ALU_OR;
         3'b111:  res = ALU_AND;
         default: res = ALU_ADD;
      endcase
      return res;
   endfunction

   // R-type funct7 must be one of the two encodings the ALU understands
   assign funct7_bad = CHECK_FUNCT7 && (funct7 != F7_BASE) && (funct7 != F7_ALT);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_FETCH;
      else     state <= state_next;
   end

   // Next-state and output decode
   always_comb begin
      state_next  = S_FETCH;
      pc_write    = 1'b0;
      adr_src     = 1'b0;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = RES_ALUOUT;
      alu_src_a   = A_PC;
      alu_src_b   = B_RS2;
      imm_src     = IMM_I;
      alu_control = ALU_ADD;
      instr_done  = 1'b0;
      illegal     = 1'b0;

      case (state)
         S_FETCH: begin
            adr_src     = 1'b0;
            ir_write    = 1'b1;
            alu_src_a   = A_PC;
            alu_src_b   = B_FOUR;
            alu_control = ALU_ADD;
            result_src  = RES_ALU;
            pc_write    = 1'b1;
            state_next  = S_DECODE;
         end
         S_DECODE: begin
            // Precompute branch/jump target into ALUOut
            alu_src_a = A_OLDPC;
            alu_src_b = B_IMM;
            imm_src   = (op == OP_JAL) ? IMM_J : IMM_B;
            case (op)
               OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
               OP_R: begin
                  if (funct7_bad) begin
                     illegal    = 1'b1;
                     instr_done = 1'b1;
                     state_next = S_FETCH;
                  end else begin
                     state_next = S_EXEC_R;
                  end
               end
               OP_I:      state_next = S_EXEC_I;
               OP_BRANCH: state_next = S_BRANCH;
               OP_JAL:    state_next = S_JAL;
               OP_JALR:   state_next = S_JALR;
               OP_LUI:    state_next = S_LUI;
               default: begin
                  illegal    = 1'b1;
                  instr_done = 1'b1;
                  state_next = S_FETCH;
               end
            endcase
         end
         S_MEM_ADR: begin
            alu_src_a  = A_RS1;
            alu_src_b  = B_IMM;
            imm_src    = (op == OP_LOAD) ? IMM_I : IMM_S;
            state_next = (op == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
         end
         S_MEM_READ: begin
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            state_next = S_MEM_WB;
         end
         S_MEM_WB: begin
            result_src = RES_MDR;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_MEM_WRITE: begin
            adr_src    = 1'b1;
            result_src = RES_ALUOUT;
            mem_write  = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a   = A_RS1;
            alu_src_b   = B_RS2;
            alu_control = alu_decode(funct3, funct7 == F7_ALT);
            state_next  = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a   = A_RS1;
            alu_src_b   = B_IMM;
            imm_src     = IMM_I;
            alu_control = alu_decode(funct3, 1'b0);
            state_next  = S_ALU_WB;
         end
         S_ALU_WB: begin
            result_src = RES_ALUOUT;
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_BRANCH: begin
            // ALUOut holds the target computed in DECODE; PC loads it if taken
            alu_src_a   = A_RS1;
            alu_src_b   = B_RS2;
            alu_control = ALU_SUB;
            result_src  = RES_ALUOUT;
            instr_done  = 1'b1;
            case (funct3)
               3'b000:  pc_write = zero;
               3'b001:  pc_write = ~zero;
               default: pc_write = 1'b0;
            endcase
            state_next = S_FETCH;
         end
         S_JAL: begin
            // PC <- target in ALUOut while ALU forms OldPC+4 for the link
            alu_src_a   = A_OLDPC;
            alu_src_b   = B_FOUR;
            alu_control = ALU_ADD;
            result_src  = RES_ALUOUT;
            pc_write    = 1'b1;
            state_next  = S_ALU_WB;
         end
         S_JALR: begin
            alu_src_a   = A_RS1;
            alu_src_b   = B_IMM;
            imm_src     = IMM_I;
            alu_control = ALU_ADD;
            state_next  = S_JALR_PC;
         end
         S_JALR_PC: begin
            alu_src_a   = A_OLDPC;
            alu_src_b   = B_FOUR;
            alu_control = ALU_ADD;
            result_src  = RES_ALUOUT;
            pc_write    = 1'b1;
            state_next  = S_ALU_WB;
         end
         S_LUI: begin
            alu_src_b   = B_IMM;
            imm_src     = IMM_U;
            alu_control = ALU_PASSB;
            state_next  = S_ALU_WB;
         end
         default: state_next = S_FETCH;
      endcase

      // Reset holds the state in FETCH; only the enables need suppressing
      if (rst) begin
         pc_write   = 1'b0;
         ir_write   = 1'b0;
         mem_write  = 1'b0;
         reg_write  = 1'b0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_main_controller.sv
// Self-checking bench for multicycle_main_controller.
// Each instruction is run to instr_done and its per-cycle enable pattern
// is compared with an instruction-level reference model.
module tb_multicycle_main_controller;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam bit         CHECK     = 1'b1;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       zero;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write;
   logic [1:0] result_src, alu_src_a, alu_src_b;
   logic [2:0] imm_src, alu_control;
   logic       instr_done, illegal;

   int tests = 0;
   int fails = 0;

   // Per-instruction observation: bit k of each mask = cycle k+1
   typedef struct packed {
      logic [3:0] n;
      logic [7:0] pcw;
      logic [7:0] irw;
      logic [7:0] memw;
      logic [7:0] regw;
      logic [7:0] done;
      logic [7:0] ill;
      logic [7:0] adr;
      logic [2:0] alu3;
      logic [2:0] imm2;
      logic [1:0] bsel1;
      logic [1:0] rsrc_last;
   } rec_t;

   multicycle_main_controller #(.CHECK_FUNCT7(CHECK)) dut (
      .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
      .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
      .reg_write(reg_write), .result_src(result_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .imm_src(imm_src), .alu_control(alu_control),
      .instr_done(instr_done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] alu_ref(input logic [2:0] f3, input logic is_sub);
      case (f3)
         3'b000:  return is_sub ? 3'b001 : 3'b000;
         3'b010:  return 3'b101;
         3'b110:  return 3'b011;
         3'b111:  return 3'b010;
         default: return 3'b000;
      endcase
   endfunction

   function automatic bit is_legal_op(input logic [6:0] o);
      return o inside {OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
   endfunction

   // Instruction-level expectations: length, which cycles write what
   function automatic rec_t model(input logic [6:0] o, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic z);
      rec_t e;
      bit   bad;
      bit   writes_reg;
      int   n;
      e          = '0;
      bad        = 1'b0;
      writes_reg = 1'b1;
      n          = 4;
      e.irw      = 8'h01;
      e.pcw      = 8'h01;
      e.bsel1    = 2'b10;
      e.imm2     = (o == OP_JAL) ? 3'b011 : 3'b010;
      case (o)
         OP_LOAD:   begin n = 5; e.adr = 8'h08; e.rsrc_last = 2'b01; end
         OP_STORE:  begin n = 4; e.adr = 8'h08; e.memw = 8'h08; writes_reg = 1'b0; end
         OP_R: begin
            if (CHECK && f7 != 7'b0000000 && f7 != 7'b0100000) bad = 1'b1;
            else e.alu3 = alu_ref(f3, f7 == 7'b0100000);
         end
         OP_I:      e.alu3 = alu_ref(f3, 1'b0);
         OP_BRANCH: begin
            n = 3; writes_reg = 1'b0; e.alu3 = 3'b001;
            if ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z)) e.pcw[2] = 1'b1;
         end
         OP_JAL:    e.pcw[2] = 1'b1;
         OP_JALR:   begin n = 5; e.pcw[3] = 1'b1; end
         OP_LUI:    e.alu3 = 3'b110;
         default:   bad = 1'b1;
      endcase
      if (bad) begin
         n = 2; writes_reg = 1'b0; e.ill = 8'h02; e.alu3 = 3'b000;
      end
      e.n    = 4'(n);
      e.done = 8'(1 << (n - 1));
      if (writes_reg) e.regw = 8'(1 << (n - 1));
      return e;
   endfunction

   // Run one instruction from FETCH until instr_done, bounded at 8 cycles
   task automatic exec_instr(input logic [6:0] o, input logic [2:0] f3,
                             input logic [6:0] f7, input logic z, output rec_t r);
      r = '0;
      op = o; funct3 = f3; funct7 = f7; zero = z;
      #1;
      for (int c = 1; c <= 8; c++) begin
         if (c > 1) begin @(posedge clk); #2; end
         r.pcw[c-1]  = pc_write;
         r.irw[c-1]  = ir_write;
         r.memw[c-1] = mem_write;
         r.regw[c-1] = reg_write;
         r.done[c-1] = instr_done;
         r.ill[c-1]  = illegal;
         r.adr[c-1]  = adr_src;
         if (c == 1) r.bsel1 = alu_src_b;
         if (c == 2) r.imm2  = imm_src;
         if (c == 3) r.alu3  = alu_control;
         if (instr_done === 1'b1) begin
            r.n = 4'(c);
            r.rsrc_last = result_src;
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rec_t dummy;
      dummy = '0;
      repeat (2) @(posedge clk);
      #2;
      tests++;
      if ({pc_write, ir_write, mem_write, reg_write, instr_done, illegal} !== 6'b0) begin
         fails++;
         $display("FAIL reset_enables: got %b expected 000000",
                  {pc_write, ir_write, mem_write, reg_write, instr_done, illegal});
      end
      tests++;
      if ({adr_src, alu_src_a, alu_src_b, result_src, alu_control} !== {1'b0, 2'b00, 2'b10, 2'b10, 3'b000}) begin
         fails++;
         $display("FAIL reset_selects: got %b expected %b",
                  {adr_src, alu_src_a, alu_src_b, result_src, alu_control}, {1'b0, 2'b00, 2'b10, 2'b10, 3'b000});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      tests++;
      if ({ir_write, pc_write, alu_src_b} !== 4'b1110) begin
         fails++;
         $display("FAIL reset_release_fetch: got %b expected 1110", {ir_write, pc_write, alu_src_b});
      end
      if (dummy.n != 4'd0) $display("unexpected");
   endtask

   task automatic test_reset_mid();
      op = OP_LOAD; funct3 = 3'b010; funct7 = 7'b0; zero = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      tests++;
      if ({adr_src, mem_write, reg_write} !== 3'b100) begin
         fails++;
         $display("FAIL mid_mem_read: got %b expected 100", {adr_src, mem_write, reg_write});
      end
      rst = 1'b1;
      #1;
      tests++;
      if ({pc_write, ir_write, mem_write, reg_write, instr_done, illegal, adr_src, alu_src_b} !== 9'b000000010) begin
         fails++;
         $display("FAIL mid_reset_outputs: got %b expected 000000010",
                  {pc_write, ir_write, mem_write, reg_write, instr_done, illegal, adr_src, alu_src_b});
      end
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      tests++;
      if ({ir_write, pc_write, alu_src_b} !== 4'b1110) begin
         fails++;
         $display("FAIL mid_reset_refetch: got %b expected 1110", {ir_write, pc_write, alu_src_b});
      end
   endtask

   task automatic test_rtype();
      rec_t r, e;
      logic [2:0] f3;
      logic [6:0] f7;
      for (int i = 0; i < 20; i++) begin
         f3 = (i == 0) ? 3'b000 : 3'($urandom);
         f7 = (i == 0 || $urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
         exec_instr(OP_R, f3, f7, 1'($urandom), r);
         e = model(OP_R, f3, f7, 1'b0);
         tests++;
         if (r !== e) begin
            fails++;
            $display("FAIL rtype f3=%b f7=%b: got %h expected %h", f3, f7, r, e);
         end
      end
   endtask

   task automatic test_itype();
      rec_t r, e;
      logic [2:0] f3;
      logic [6:0] f7;
      for (int i = 0; i < 16; i++) begin
         f3 = 3'($urandom);
         f7 = 7'($urandom);
         exec_instr(OP_I, f3, f7, 1'($urandom), r);
         e = model(OP_I, f3, f7, 1'b0);
         tests++;
         if (r !== e) begin
            fails++;
            $display("FAIL itype f3=%b f7=%b: got %h expected %h", f3, f7, r, e);
         end
      end
   endtask

   task automatic test_load_store();
      rec_t r, e;
      logic [6:0] o;
      for (int i = 0; i < 10; i++) begin
         o = i[0] ? OP_STORE : OP_LOAD;
         exec_instr(o, 3'b010, 7'($urandom), 1'($urandom), r);
         e = model(o, 3'b010, 7'b0, 1'b0);
         tests++;
         if (r !== e) begin
            fails++;
            $display("FAIL load_store op=%b: got %h expected %h", o, r, e);
         end
      end
   endtask

   task automatic test_branch();
      rec_t r, e;
      logic [2:0] f3;
      logic       z;
      for (int i = 0; i < 16; i++) begin
         f3 = (i < 4) ? {2'b00, i[1]} : 3'($urandom);
         z  = (i < 4) ? i[0] : 1'($urandom);
         exec_instr(OP_BRANCH, f3, 7'($urandom), z, r);
         e = model(OP_BRANCH, f3, 7'b0, z);
         tests++;
         if (r !== e) begin
            fails++;
            $display("FAIL branch f3=%b zero=%b: got %h expected %h", f3, z, r, e);
         end
      end
   endtask

   task automatic test_jumps();
      rec_t r, e;
      logic [6:0] o;
      for (int i = 0; i < 6; i++) begin
         case (i % 3)
            0:       o = OP_JAL;
            1:       o = OP_JALR;
            default: o = OP_LUI;
         endcase
         exec_instr(o, 3'($urandom), 7'($urandom), 1'($urandom), r);
         e = model(o, 3'b0, 7'b0, 1'b0);
         tests++;
         if (r !== e) begin
            fails++;
            $display("FAIL jump_lui op=%b: got %h expected %h", o, r, e);
         end
      end
   endtask

   task automatic test_illegal();
      rec_t r, e;
      logic [6:0] o;
      logic [6:0] f7;
      for (int i = 0; i < 12; i++) begin
         if (i == 0) begin o = 7'b0000000; f7 = 7'b0; end
         else if (i == 1) begin o = OP_R; f7 = 7'b0000001; end
         else if (i[0]) begin
            o = OP_R;
            do f7 = 7'($urandom); while (f7 == 7'b0000000 || f7 == 7'b0100000);
         end else begin
            do o = 7'($urandom); while (is_legal_op(o));
            f7 = 7'($urandom);
         end
         exec_instr(o, 3'($urandom), f7, 1'($urandom), r);
         e = model(o, 3'b0, f7, 1'b0);
         tests++;
         if (r !== e) begin
            fails++;
            $display("FAIL illegal op=%b f7=%b: got %h expected %h", o, f7, r, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      rec_t r, e;
      logic [6:0] ops [8];
      logic [6:0] o;
      logic [2:0] f3;
      logic [6:0] f7;
      logic       z;
      ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
      for (int i = 0; i < 150; i++) begin
         int k;
         k = $urandom_range(0, 8);
         o = (k == 8) ? 7'($urandom) : ops[k];
         f3 = 3'($urandom);
         f7 = ($urandom_range(0, 3) == 0) ? 7'($urandom) : {1'b0, 1'($urandom), 5'b0};
         z  = 1'($urandom);
         exec_instr(o, f3, f7, z, r);
         e = model(o, f3, f7, z);
         tests++;
         if (r !== e) begin
            fails++;
            $display("FAIL back_to_back op=%b f3=%b f7=%b zero=%b: got %h expected %h",
                     o, f3, f7, z, r, e);
         end
      end
   endtask

   initial begin
      rst = 1'b1; op = 7'b0; funct3 = 3'b0; funct7 = 7'b0; zero = 1'b0;
      test_reset();
      test_rtype();
      test_itype();
      test_load_store();
      test_reset_mid();
      test_branch();
      test_jumps();
      test_illegal();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
